dac_frame_scheduler: RTL and testbench

Sequences each sample period of the dual-channel waveform generator. It produces the `clk_sampling` tick that advances the waveform datapaths and waits for their pipeline to settle. It then captures the channel A/B 12-bit DAC words and issues them as 16-bit command frames to the SPI master over a req/ack handshake, finishing with an optional LDAC strobe so both DAC outputs update together. It sits between the waveform generators and the SPI master.

---
 rtl/dac_frame_scheduler.sv | 179 +++++++++++++++++
 tb/tb_dac_frame_scheduler.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_frame_scheduler.sv
// Sample tick generator and DAC A/B SPI frame sequencer for the wavegen.
// Define WAVEGEN_LDAC_SYNC_EN for a shared LDAC strobe after the last frame.
module dac_frame_scheduler #(
  parameter int unsigned SAMPLE_DIV    = 2000,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter logic [2:0]  CMD_BITS      = 3'b011,
  parameter int unsigned LDAC_CYCLES   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable_a,
  input  logic        enable_b,
  input  logic [11:0] dac_a_word,
  input  logic [11:0] dac_b_word,
  input  logic        spi_ack,
  input  logic        clr_overrun,
  output logic        clk_sampling,
  output logic        spi_req,
  output logic [15:0] spi_data,
  output logic        ldac_n,
  output logic        busy,
  output logic        overrun,
  output logic        overrun_flag
);

  localparam int CW = $clog2(SAMPLE_DIV);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);

  if (SAMPLE_DIV < 2 || SETTLE_CYCLES < 1 || LDAC_CYCLES < 1) begin : g_bad_param
    $error("dac_frame_scheduler: parameter out of range");
  end

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    XFER_A,
`ifdef WAVEGEN_LDAC_SYNC_EN
    XFER_B,
    LATCH
`else
    XFER_B
`endif
  } state_t;

`ifdef WAVEGEN_LDAC_SYNC_EN
  localparam state_t DONE = LATCH;
  localparam int LW = $clog2(LDAC_CYCLES + 1);
  logic [LW-1:0] lcnt;
`else
  localparam state_t DONE = IDLE;
`endif

  state_t        state;
  state_t        state_d;
  logic [CW-1:0] cnt;
  logic [SW-1:0] scnt;
  logic [11:0]   word_b;
  logic          en_b_q;
  logic          tick_d;
  logic          frame_done;

  assign tick_d     = (cnt == CW'(SAMPLE_DIV - 2));
  assign frame_done = spi_req && spi_ack;

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: begin
        if (clk_sampling) state_d = SETTLE;
      end
      SETTLE: begin
        if (scnt == '0) begin
          if (enable_a)      state_d = XFER_A;
          else if (enable_b) state_d = XFER_B;
          else               state_d = IDLE;
        end
      end
      XFER_A: begin
        if (frame_done) state_d = en_b_q ? XFER_B : DONE;
      end
      XFER_B: begin
        if (frame_done) state_d = DONE;
      end
`ifdef WAVEGEN_LDAC_SYNC_EN
      LATCH: begin
        if (lcnt == '0) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // overrun looks ahead at state_d so the pulse lines up with the dropped tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt          <= '0;
      clk_sampling <= 1'b0;
      state        <= IDLE;
      scnt         <= '0;
      word_b       <= '0;
      en_b_q       <= 1'b0;
      spi_req      <= 1'b0;
      spi_data     <= '0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
      overrun_flag <= 1'b0;
`ifdef WAVEGEN_LDAC_SYNC_EN
      lcnt         <= '0;
      ldac_n       <= 1'b1;
`endif
    end else begin
      cnt          <= (cnt == CW'(SAMPLE_DIV - 1)) ? '0 : cnt + 1'b1;
      clk_sampling <= tick_d;
      state        <= state_d;
      busy         <= (state_d != IDLE);
      overrun      <= tick_d && (state_d != IDLE);
      if (overrun)          overrun_flag <= 1'b1;
      else if (clr_overrun) overrun_flag <= 1'b0;

      unique case (state)
        IDLE: begin
          scnt <= SW'(SETTLE_CYCLES - 1);
        end
        SETTLE: begin
          if (scnt != '0) begin
            scnt <= scnt - 1'b1;
          end else begin
            word_b <= dac_b_word;
            en_b_q <= enable_b;
            if (enable_a) begin
              spi_req  <= 1'b1;
              spi_data <= {1'b0, CMD_BITS, dac_a_word};
            end else if (enable_b) begin
              spi_req  <= 1'b1;
              spi_data <= {1'b1, CMD_BITS, dac_b_word};
            end
          end
        end
        XFER_A: begin
          if (frame_done) begin
            spi_req <= 1'b0;
            if (en_b_q) begin
              spi_data <= {1'b1, CMD_BITS, word_b};
            end else begin
`ifdef WAVEGEN_LDAC_SYNC_EN
              ldac_n <= 1'b0;
              lcnt   <= LW'(LDAC_CYCLES - 1);
`endif
            end
          end
        end
        XFER_B: begin
          // entered from XFER_A with req low: one idle gap, then request
          if (!spi_req) begin
            spi_req <= 1'b1;
          end else if (spi_ack) begin
            spi_req <= 1'b0;
`ifdef WAVEGEN_LDAC_SYNC_EN
            ldac_n  <= 1'b0;
            lcnt    <= LW'(LDAC_CYCLES - 1);
`endif
          end
        end
`ifdef WAVEGEN_LDAC_SYNC_EN
        LATCH: begin
          if (lcnt == '0) ldac_n <= 1'b1;
          else            lcnt   <= lcnt - 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

`ifndef WAVEGEN_LDAC_SYNC_EN
  assign ldac_n = 1'b0;
`endif

endmodule

// File: tb/tb_dac_frame_scheduler.sv
// Scoreboard bench for dac_frame_scheduler (SAMPLE_DIV=20, SETTLE_CYCLES=4).
module tb_dac_frame_scheduler;

  localparam int DIV = 20;
  localparam logic [2:0] CMD = 3'b011;
`ifdef WAVEGEN_LDAC_SYNC_EN
  localparam int LX = 2;
  localparam logic LDAC_IDLE = 1'b1;
`else
  localparam int LX = 0;
  localparam logic LDAC_IDLE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable_a = 1'b0;
  logic        enable_b = 1'b0;
  logic [11:0] dac_a_word = '0;
  logic [11:0] dac_b_word = '0;
  logic        spi_ack;
  logic        clr_overrun = 1'b0;
  logic        clk_sampling;
  logic        spi_req;
  logic [15:0] spi_data;
  logic        ldac_n;
  logic        busy;
  logic        overrun;
  logic        overrun_flag;

  int tests = 0;
  int fails = 0;
  int cyc;
  int ov_count = 0;
  int ack_delay = 10;
  bit stray = 1'b0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  dac_frame_scheduler #(
    .SAMPLE_DIV(DIV),
    .SETTLE_CYCLES(4),
    .CMD_BITS(CMD),
    .LDAC_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable_a(enable_a),
    .enable_b(enable_b),
    .dac_a_word(dac_a_word),
    .dac_b_word(dac_b_word),
    .spi_ack(spi_ack),
    .clr_overrun(clr_overrun),
    .clk_sampling(clk_sampling),
    .spi_req(spi_req),
    .spi_data(spi_data),
    .ldac_n(ldac_n),
    .busy(busy),
    .overrun(overrun),
    .overrun_flag(overrun_flag)
  );

  always @(posedge clk or posedge rst)
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // SPI master model: ack ack_delay cycles after req is first seen
  initial begin : responder
    int cnt;
    bit active;
    active = 1'b0;
    cnt = 0;
    spi_ack = 1'b0;
    forever begin
      @(negedge clk);
      spi_ack = 1'b0;
      if (rst) begin
        active = 1'b0;
      end else if (stray) begin
        spi_ack = 1'b1;
        stray = 1'b0;
      end else if (spi_req) begin
        if (!active) begin
          active = 1'b1;
          cnt = ack_delay;
        end
        if (cnt == 0) begin
          spi_ack = 1'b1;
          active = 1'b0;
        end else begin
          cnt--;
        end
      end
    end
  end

  initial begin : monitor
    bit prev;
    bit stable;
    int lw;
    logic [15:0] cur;
    prev = 1'b0;
    stable = 1'b1;
    lw = 0;
    cur = '0;
    forever begin
      @(negedge clk);
      #1;
      if (spi_req && !prev) begin
        cur = spi_data;
        stable = 1'b1;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_frame: got 0x%0h, expected no frame", spi_data);
        end else begin
          check("frame", 32'(spi_data), 32'(exp_q.pop_front()));
        end
        check("ldac_during_frame", 32'(ldac_n), 32'(LDAC_IDLE));
      end else if (spi_req && spi_data !== cur) begin
        stable = 1'b0;
      end
      if (!spi_req && prev) check("frame_stable", 32'(stable), 32'd1);
      prev = spi_req;
      if (overrun === 1'b1) ov_count++;
`ifdef WAVEGEN_LDAC_SYNC_EN
      if (ldac_n === 1'b0) lw++;
      else if (lw > 0) begin
        check("ldac_width", 32'(lw), 32'd2);
        lw = 0;
      end
`endif
    end
  end

  task automatic tick_scan(input int upto);
    int bad_rst;
    int bad_tick;
    bad_rst = 0;
    bad_tick = 0;
    for (int c = 0; c <= upto; c++) begin
      if (c > 0) @(negedge clk);
      if (c % DIV == DIV - 1) begin
        check($sformatf("tick_c%0d", c), 32'(clk_sampling), 32'd1);
      end else if (clk_sampling !== 1'b0) begin
        bad_tick++;
      end
      if (c < DIV - 1 &&
          {clk_sampling, spi_req, spi_data, ldac_n, busy, overrun, overrun_flag} !==
          {1'b0, 1'b0, 16'h0, LDAC_IDLE, 1'b0, 1'b0, 1'b0})
        bad_rst++;
    end
    check("reset_values", 32'(bad_rst), 32'd0);
    check("tick_only_at_div", 32'(bad_tick), 32'd0);
  endtask

  task automatic wait_tick(output int t, output bit ok);
    int guard;
    guard = 0;
    while (!(clk_sampling === 1'b1 && busy === 1'b0) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    ok = (guard < 100);
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL tick_wait: no accepted tick in 100 cycles, got none, expected one");
    end
    t = cyc;
  endtask

  task automatic run_period(input bit ea, input bit eb, input logic [11:0] a,
                            input logic [11:0] b, input int dly, input int blen,
                            input int ovr, input int clr_at, input int stray_at);
    int t;
    int n;
    int ov0;
    int guard;
    bit ok;
    guard = 0;
    while (busy && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    enable_a = ea;
    enable_b = eb;
    dac_a_word = a;
    dac_b_word = b;
    ack_delay = dly;
    if (ea) exp_q.push_back({1'b0, CMD, a});
    if (eb) exp_q.push_back({1'b1, CMD, b});
    wait_tick(t, ok);
    if (!ok) return;
    ov0 = ov_count;
    n = 0;
    while (n == 0 || (busy && n < 200)) begin
      @(negedge clk);
      n = cyc - t;
      clr_overrun = (n == clr_at);
      if (n == stray_at) stray = 1'b1;
      if (n == 1) check("busy_rise", 32'(busy), 32'd1);
      if (n == 5) begin
        dac_a_word = ~a;
        dac_b_word = ~b;
        enable_a = ~ea;
        enable_b = ~eb;
      end
    end
    clr_overrun = 1'b0;
    check("busy_len", 32'(n - 1), 32'(blen));
    check("overrun_count", 32'(ov_count - ov0), 32'(ovr));
  endtask

  task automatic clear_flag();
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    check("flag_cleared", 32'(overrun_flag), 32'd0);
  endtask

  initial begin : stim
    int t;
    int guard;
    bit ok;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    tick_scan(3 * DIV - 1);

    run_period(1, 1, 12'h123, 12'hABC, 10, 27 + LX, 1, -1, -1);
    check("flag_after_drop", 32'(overrun_flag), 32'd1);
    run_period(0, 1, 12'h000, 12'h7FF, 10, 15 + LX, 0, -1, -1);
    run_period(0, 0, 12'h555, 12'h666, 10, 4, 0, -1, 2);
    run_period(1, 0, 12'h456, 12'h000, 3, 8 + LX, 0, -1, -1);

    check("flag_sticky", 32'(overrun_flag), 32'd1);
    clear_flag();
    run_period(1, 0, 12'h001, 12'h000, 30, 35 + LX, 1, -1, -1);
    check("flag_set_by_drop", 32'(overrun_flag), 32'd1);
    clear_flag();
    run_period(1, 0, 12'h002, 12'h000, 30, 35 + LX, 1, 20, -1);
    check("flag_set_wins", 32'(overrun_flag), 32'd1);

    // async reset while channel A frame is outstanding
    guard = 0;
    while (busy && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    enable_a = 1'b1;
    enable_b = 1'b0;
    dac_a_word = 12'h2A5;
    ack_delay = 1000;
    exp_q.push_back(16'h32A5);
    wait_tick(t, ok);
    guard = 0;
    while (cyc - t < 7 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("req_before_rst", 32'(spi_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_req", 32'(spi_req), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_data", 32'(spi_data), 32'd0);
    check("rst_ldac", 32'(ldac_n), 32'(LDAC_IDLE));
    enable_a = 1'b0;
    ack_delay = 10;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick_scan(DIV - 1);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
